// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART receiver: FSM states, lcr field
// positions, status-bit positions and the FIFO entry width.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2,
        ST_BRKWAIT
    } rx_state_e;

    localparam int LCR_WLEN_LSB = 0;
    localparam int LCR_WLEN_MSB = 1;
    localparam int LCR_STOP2    = 2;
    localparam int LCR_PEN      = 3;
    localparam int LCR_EPS      = 4;

    localparam int STAT_PAR = 0;
    localparam int STAT_FRM = 1;
    localparam int STAT_BRK = 2;
    localparam int STAT_W   = 3;

    localparam int ENTRY_W = STAT_W + 8;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with occupancy count and a sticky
// overrun flag; a push into a full FIFO is accepted only alongside a pop.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = ENTRY_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    input  logic                     ovr_clr_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     overrun_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             overrun_q;
    logic             empty, full, do_pop, do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push_i && full && !do_pop) overrun_q <= 1'b1;
            else if (ovr_clr_i)            overrun_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign rd_data_o = empty ? '0 : mem_q[rd_ptr_q];
    assign valid_o   = !empty;
    assign count_o   = count_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with runtime line control (lcr) feeding a FWFT FIFO.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around mid-bit.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          tick_os,
    input  logic                          rx,
    input  logic [4:0]                    lcr,
    output logic [7:0]                    m_data,
    output logic [2:0]                    m_status,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overrun,
    input  logic                          ovr_clr,
    output logic                          rx_busy
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] LAST_T = CNT_W'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] SAMP_T = CNT_W'(OVERSAMPLE / 2);
`else
    localparam logic [CNT_W-1:0] SAMP_T = CNT_W'(OVERSAMPLE / 2 - 1);
`endif

    logic               rx_s1_q, rx_s2_q;
    rx_state_e          state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         data_q;
    logic [4:0]         lcr_q;
    logic               all_low_q, perr_q, ferr_q;

    logic               samp, samp_evt, bit_end, brk_now, exp_par, push;
    logic [2:0]         nbits_m1;
    logic [ENTRY_W-1:0] push_data, rd_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
        end else begin
            rx_s1_q <= rx;
            rx_s2_q <= rx_s1_q;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] early_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            early_q <= 2'b11;
        end else if (tick_os) begin
            if (cnt_q == SAMP_T - CNT_W'(2)) early_q[0] <= rx_s2_q;
            if (cnt_q == SAMP_T - CNT_W'(1)) early_q[1] <= rx_s2_q;
        end
    end

    assign samp = maj3(early_q[0], early_q[1], rx_s2_q);
`else
    assign samp = rx_s2_q;
`endif

    assign samp_evt = tick_os && (cnt_q == SAMP_T);
    assign bit_end  = tick_os && (cnt_q == LAST_T);
    assign nbits_m1 = {1'b0, lcr_q[LCR_WLEN_MSB:LCR_WLEN_LSB]} + 3'd4;
    // Unreceived data bits are held at zero, so a full-byte reduction is exact.
    assign exp_par  = lcr_q[LCR_EPS] ? ^data_q : ~^data_q;
    assign brk_now  = all_low_q && ferr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            lcr_q     <= '0;
            all_low_q <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            if (tick_os && state_q != ST_IDLE)
                cnt_q <= (cnt_q == LAST_T) ? '0 : cnt_q + 1'b1;
            unique case (state_q)
                // The tick that first sees low counts as tick 0 of the start bit.
                ST_IDLE: begin
                    if (tick_os && !rx_s2_q) begin
                        state_q <= ST_START;
                        cnt_q   <= CNT_W'(1);
                    end
                end
                ST_START: begin
                    if (samp_evt && samp) begin
                        state_q <= ST_IDLE;
                    end else if (bit_end) begin
                        state_q   <= ST_DATA;
                        lcr_q     <= lcr;
                        bit_idx_q <= '0;
                        data_q    <= '0;
                        all_low_q <= 1'b1;
                        perr_q    <= 1'b0;
                        ferr_q    <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (samp_evt) begin
                        data_q[bit_idx_q] <= samp;
                        if (samp) all_low_q <= 1'b0;
                    end
                    if (bit_end) begin
                        if (bit_idx_q == nbits_m1)
                            state_q <= lcr_q[LCR_PEN] ? ST_PARITY : ST_STOP1;
                        else
                            bit_idx_q <= bit_idx_q + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (samp_evt) begin
                        perr_q <= (samp != exp_par);
                        if (samp) all_low_q <= 1'b0;
                    end
                    if (bit_end) state_q <= ST_STOP1;
                end
                ST_STOP1: begin
                    if (samp_evt && !samp) ferr_q <= 1'b1;
                    if (bit_end) begin
                        if (brk_now)                 state_q <= ST_BRKWAIT;
                        else if (lcr_q[LCR_STOP2])   state_q <= ST_STOP2;
                        else                         state_q <= ST_IDLE;
                    end
                end
                ST_STOP2: begin
                    if (samp_evt && !samp) ferr_q <= 1'b1;
                    if (bit_end) state_q <= ST_IDLE;
                end
                ST_BRKWAIT: begin
                    if (tick_os && rx_s2_q) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Push in the same cycle as the final stop-bit end tick.
    assign push = bit_end &&
                  (((state_q == ST_STOP1) && (brk_now || !lcr_q[LCR_STOP2])) ||
                   (state_q == ST_STOP2));

    always_comb begin
        push_data = '0;
        if (state_q == ST_STOP1 && brk_now) begin
            push_data[8 + STAT_BRK] = 1'b1;
            push_data[8 + STAT_FRM] = 1'b1;
            push_data[8 + STAT_PAR] = perr_q;
        end else begin
            push_data[7:0]          = data_q;
            push_data[8 + STAT_FRM] = ferr_q;
            push_data[8 + STAT_PAR] = perr_q;
        end
    end

    uart_rx_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (m_ready),
        .ovr_clr_i   (ovr_clr),
        .rd_data_o   (rd_data),
        .valid_o     (m_valid),
        .count_o     (count),
        .overrun_o   (overrun)
    );

    assign m_data   = rd_data[7:0];
    assign m_status = rd_data[ENTRY_W-1:8];
    assign rx_busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed and randomized frames against a frame-level reference model of the receiver.
module tb_uart_rx_cfg;

    localparam int OS    = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_os = 1'b0;
    logic       rx = 1'b1;
    logic [4:0] lcr = 5'b00011;
    logic       m_ready = 1'b0;
    logic       ovr_clr = 1'b0;
    logic [7:0] m_data;
    logic [2:0] m_status;
    logic       m_valid;
    logic [2:0] count;
    logic       overrun;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;
    int unsigned div = 0;
    logic [10:0] exp_q[$];

    uart_rx_cfg #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick_os  (tick_os),
        .rx       (rx),
        .lcr      (lcr),
        .m_data   (m_data),
        .m_status (m_status),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .count    (count),
        .overrun  (overrun),
        .ovr_clr  (ovr_clr),
        .rx_busy  (rx_busy)
    );

    always #5 clk = ~clk;

    // Oversample strobe: one clock high in every four.
    initial forever begin
        @(posedge clk);
        #1;
        div = (div + 1) % 4;
        tick_os = (div == 0);
    end

    initial begin
        #600_000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Returns at the falling edge just before a tick-bearing rising edge.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(negedge clk); while (!tick_os);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(OS);
    endtask

    // Expected FIFO entry {brk, frame_err, parity_err, data} for one frame.
    function automatic logic [10:0] model(input logic [4:0] l, input logic [7:0] d,
                                          input logic pbit, input logic s1, input logic s2);
        int         n;
        logic [7:0] dm;
        logic       ep, perr, ferr, brk;
        n    = 5 + int'(l[1:0]);
        dm   = d & 8'((1 << n) - 1);
        ep   = l[4] ? ^dm : ~^dm;
        perr = l[3] && (pbit != ep);
        ferr = !s1 || (l[2] && !s2);
        brk  = (dm == 8'h00) && (!l[3] || !pbit) && !s1;
        if (brk) return {1'b1, 1'b1, perr, 8'h00};
        return {1'b0, ferr, perr, dm};
    endfunction

    // Ends at the falling edge just before the DUT's final stop-bit end tick.
    task automatic send_frame(input logic [4:0] l, input logic [7:0] d, input logic pbit,
                              input logic s1, input logic s2, input bit scramble);
        lcr = l;
        wait_ticks(1);
        send_bit(1'b0);
        for (int i = 0; i < 5 + int'(l[1:0]); i++) begin
            send_bit(d[i]);
            if (scramble && i == 1) lcr = 5'($urandom);
        end
        if (l[3]) send_bit(pbit);
        send_bit(s1);
        if (l[2]) send_bit(s2);
    endtask

    task automatic frame(input logic [4:0] l, input logic [7:0] d, input logic pbit,
                         input logic s1, input logic s2, input bit scramble);
        send_frame(l, d, pbit, s1, s2, scramble);
        if (exp_q.size() < DEPTH) exp_q.push_back(model(l, d, pbit, s1, s2));
        rx = 1'b1;
        wait_ticks(2 * OS);
    endtask

    task automatic pop_check(input string tag);
        logic [10:0] e;
        e = exp_q.pop_front();
        check({tag, ".valid"},  m_valid,  1);
        check({tag, ".data"},   m_data,   e[7:0]);
        check({tag, ".status"}, m_status, e[10:8]);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] d6;
        logic [4:0] rl;
        logic [7:0] rd;
        logic       rp, rs1, rs2;

        repeat (3) @(negedge clk);
        check("rst.valid",   m_valid,  0);
        check("rst.count",   count,    0);
        check("rst.overrun", overrun,  0);
        check("rst.busy",    rx_busy,  0);
        check("rst.data",    m_data,   0);
        check("rst.status",  m_status, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 8N1 0xA5
        frame(5'b00011, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
        check("a5.count",  count,    1);
        check("a5.data",   m_data,   8'hA5);
        check("a5.status", m_status, 3'b000);
        pop_check("a5");
        check("a5.empty", m_valid, 0);

        // 5 bits, even parity sent wrong, second stop low
        frame(5'b11100, 8'h13, 1'b0, 1'b1, 1'b0, 1'b0);
        check("par.data",   m_data,   8'h13);
        check("par.status", m_status, 3'b011);
        pop_check("par");

        // Break: rx low for 20 bit periods
        lcr = 5'b00011;
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(20 * OS);
        check("brk.count",  count,    1);
        check("brk.busy",   rx_busy,  1);
        check("brk.data",   m_data,   8'h00);
        check("brk.status", m_status, 3'b110);
        rx = 1'b1;
        wait_ticks(3);
        check("brk.idle", rx_busy, 0);
        exp_q.push_back(11'h600);
        pop_check("brk");
        wait_ticks(OS);
        check("brk.single", count, 0);

        // Quarter-bit glitch
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(OS / 4);
        check("glitch.busy_mid", rx_busy, 1);
        rx = 1'b1;
        wait_ticks(2 * OS);
        check("glitch.busy",  rx_busy, 0);
        check("glitch.count", count,   0);

        // Overrun: five frames into a four-entry FIFO
        for (int i = 0; i < 5; i++)
            frame(5'b00011, 8'($urandom), 1'b0, 1'b1, 1'b1, 1'b0);
        check("ovr.count",   count,   4);
        check("ovr.flag",    overrun, 1);
        check("ovr.valid",   m_valid, 1);
        d6 = 8'($urandom);
        send_frame(5'b00011, d6, 1'b0, 1'b1, 1'b1, 1'b0);
        check("ovr.head", m_data, exp_q[0][7:0]);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(model(5'b00011, d6, 1'b0, 1'b1, 1'b1));
        rx = 1'b1;
        wait_ticks(OS);
        check("ovr.count_full", count,   4);
        check("ovr.flag_held",  overrun, 1);
        ovr_clr = 1'b1;
        @(negedge clk);
        ovr_clr = 1'b0;
        check("ovr.cleared", overrun, 0);
        for (int i = 0; i < DEPTH; i++) pop_check("ovr.drain");
        check("ovr.drained", count, 0);

        // Reset in the middle of the data bits
        frame(5'b00011, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0);
        lcr = 5'b00011;
        wait_ticks(1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        check("mid.busy",   rx_busy,  0);
        check("mid.count",  count,    0);
        check("mid.valid",  m_valid,  0);
        check("mid.data",   m_data,   0);
        check("mid.status", m_status, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(2 * OS);
        check("mid.nopush", count, 0);
        frame(5'b00011, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
        check("mid.next_data", m_data, 8'h5A);
        pop_check("mid.next");

        // Randomized frames, some with lcr changed mid-frame
        for (int i = 0; i < 10; i++) begin
            rl  = 5'($urandom);
            rd  = 8'($urandom);
            rp  = 1'($urandom);
            rs1 = ($urandom_range(0, 5) != 0);
            rs2 = 1'($urandom);
            frame(rl, rd, rp, rs1, rs2, bit'(i % 2));
            pop_check("rnd");
        end
        check("rnd.empty", count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
